// File: rtl/vme_reg_pkg.sv
// VME register file shared definitions: address map, FSM states, ID default.
package vme_reg_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_REG_BASE = 8'h01;
    localparam logic [7:0] ADDR_ID       = 8'hFF;

    localparam logic [31:0] DEF_ID_VALUE = 32'h4B4F5430;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        BUSY
    } state_t;

endpackage

// File: rtl/vme_reg_file.sv
// VME-side register file: local-bus decode, CTRL/REG/ID access, pulse bits,
// strobe-held acknowledge.
module vme_reg_file
    import vme_reg_pkg::*;
#(
    parameter int                N_CTRL     = 15,
    parameter int                N_REG      = 58,
    parameter int                AW         = 8,
    parameter logic [N_CTRL-1:0] PULSE_MASK = '0,
    parameter logic [31:0]       ID_VALUE   = DEF_ID_VALUE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       bus_addr,
    input  logic [31:0]         bus_wdata,
    input  logic                bus_wr,
    input  logic                bus_rd,
    output logic [31:0]         bus_rdata,
    output logic                bus_ack,
    output logic                bus_err,
    output logic [N_CTRL-1:0]   ctrl_out,
    output logic [N_REG*32-1:0] reg_out
);

    localparam int IW = $clog2(N_REG);

    state_t            state;
    state_t            state_nx;
    logic [N_CTRL-1:0] ctrl_q;
    logic [31:0]       regs [N_REG];
    logic [31:0]       rdata_q;
    logic              err_q;

    logic          go;
    logic          both;
    logic          is_ctrl;
    logic          is_reg;
    logic          is_id;
    logic          wr_ok;
    logic [IW-1:0] ridx;
    logic [31:0]   rd_val;

    assign go      = (state == IDLE) && (bus_wr || bus_rd);
    assign both    = bus_wr && bus_rd;
    assign is_ctrl = bus_addr == AW'(ADDR_CTRL);
    assign is_reg  = (bus_addr >= AW'(ADDR_REG_BASE)) &&
                     (bus_addr <= AW'(N_REG));
    assign is_id   = bus_addr == AW'(ADDR_ID);
    assign ridx    = IW'(bus_addr - AW'(1));
    assign wr_ok   = go && bus_wr && !bus_rd && (is_ctrl || is_reg);

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            is_ctrl: rd_val = 32'(ctrl_q & ~PULSE_MASK);
            is_reg:  rd_val = regs[ridx];
            is_id:   rd_val = ID_VALUE;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SYNC:    if (!bus_wr && !bus_rd) state_nx = IDLE;
            IDLE:    if (bus_wr || bus_rd) state_nx = BUSY;
            BUSY:    if (!bus_wr && !bus_rd) state_nx = IDLE;
            default: state_nx = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SYNC;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) begin
                if (both) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end else if (bus_wr) begin
                    err_q   <= !(is_ctrl || is_reg);
                    rdata_q <= '0;
                end else begin
                    err_q   <= !(is_ctrl || is_reg || is_id);
                    rdata_q <= rd_val;
                end
            end
        end
    end

    // Pulse bits decay on every edge that does not rewrite CTRL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (wr_ok && is_ctrl) begin
            ctrl_q <= bus_wdata[N_CTRL-1:0];
        end else begin
            ctrl_q <= ctrl_q & ~PULSE_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REG; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < N_REG; k++) begin
                if (wr_ok && is_reg && ridx == IW'(k)) regs[k] <= bus_wdata;
            end
        end
    end

    assign bus_ack   = state == BUSY;
    assign bus_rdata = rdata_q;
    assign bus_err   = err_q;
    assign ctrl_out  = ctrl_q;

    for (genvar g = 0; g < N_REG; g++) begin : g_flat
        assign reg_out[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_vme_reg_file.sv
// Scoreboard bench for vme_reg_file: directed map/pulse/error/reset cases
// followed by randomized accesses against an array-based reference model.
module tb_vme_reg_file;

    localparam int          N_CTRL = 15;
    localparam int          N_REG  = 58;
    localparam int          AW     = 8;
    localparam logic [14:0] PM     = 15'h0001;
    localparam logic [31:0] ID     = 32'h4B4F5430;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [AW-1:0]       bus_addr = '0;
    logic [31:0]         bus_wdata = '0;
    logic                bus_wr = 1'b0;
    logic                bus_rd = 1'b0;
    logic [31:0]         bus_rdata;
    logic                bus_ack;
    logic                bus_err;
    logic [N_CTRL-1:0]   ctrl_out;
    logic [N_REG*32-1:0] reg_out;

    vme_reg_file #(
        .N_CTRL(N_CTRL),
        .N_REG(N_REG),
        .AW(AW),
        .PULSE_MASK(PM),
        .ID_VALUE(ID)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wr(bus_wr),
        .bus_rd(bus_rd),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .bus_err(bus_err),
        .ctrl_out(ctrl_out),
        .reg_out(reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_rd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [14:0] ctrl_m = '0;
    logic [31:0] regs_m [N_REG];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        int bad;
        bad = -1;
        checks++;
        for (int k = 0; k < N_REG; k++)
            if (bad < 0 && reg_out[32*k +: 32] !== regs_m[k]) bad = k;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: REG[%0d] got %h expected %h", name, bad,
                     reg_out[32*bad +: 32], regs_m[bad]);
        end
    endtask

    task automatic model_reset();
        ctrl_m = '0;
        for (int k = 0; k < N_REG; k++) regs_m[k] = '0;
    endtask

    // Reference model: applies the access and returns the bus response.
    function automatic exp_t model(input logic [7:0] a, input logic [31:0] d,
                                   input logic wr, input logic rd);
        exp_t e;
        int   ai;
        e.chk_rd = 1'b1;
        e.rdata  = '0;
        e.err    = 1'b0;
        ai = int'(a);
        if (wr && rd) begin
            e.err = 1'b1;
        end else if (wr) begin
            if (ai == 0) begin
                ctrl_m   = d[14:0] & ~PM;
                e.chk_rd = 1'b0;
            end else if (ai >= 1 && ai <= N_REG) begin
                regs_m[ai-1] = d;
                e.chk_rd     = 1'b0;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            if (ai == 0) e.rdata = {17'd0, ctrl_m};
            else if (ai >= 1 && ai <= N_REG) e.rdata = regs_m[ai-1];
            else if (ai == 255) e.rdata = ID;
            else e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: compares the bus response on every rising acknowledge.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (bus_ack && !ack_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with empty queue");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                if (e.chk_rd) chk("bus_rdata", bus_rdata, e.rdata);
            end
        end
        ack_prev <= bus_ack;
    end

    task automatic access(input logic [7:0] a, input logic [31:0] d,
                          input logic wr, input logic rd, input int hold);
        exp_t e;
        logic held;
        int   n;
        e = model(a, d, wr, rd);
        exp_q.push_back(e);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = wr;
        bus_rd    = rd;
        @(negedge clk);
        chk("ack_rise", {31'd0, bus_ack}, 32'd1);
        if (wr && !rd && a == 8'h00)
            chk("pulse_hi", 32'(ctrl_out), 32'(d[14:0]));
        held = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus_addr  = 8'($urandom);
            bus_wdata = $urandom;
            @(negedge clk);
            if (!bus_ack) held = 1'b0;
        end
        chk("ack_held", {31'd0, held}, 32'd1);
        chk("ctrl_out", 32'(ctrl_out), 32'(ctrl_m));
        chk_regs("reg_out");
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        @(negedge clk);
        chk("ack_fall", {31'd0, bus_ack}, 32'd0);
        n = 0;
        while (bus_ack && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, bus_ack}, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_ctrl", 32'(ctrl_out), 32'd0);
        chk_regs("rst_regs");
        rst_n = 1'b1;
        @(negedge clk);

        access(8'h00, 32'h0000_7FFF, 1, 0, 2);
        access(8'h00, 32'h0, 0, 1, 3);
        access(8'h3A, 32'hDEAD_BEEF, 1, 0, 1);
        chk("reg57", reg_out[1855:1824], 32'hDEAD_BEEF);
        access(8'hFF, 32'h0, 0, 1, 1);
        access(8'h00, 32'h0000_0003, 1, 0, 1);
        access(8'h00, 32'h0, 0, 1, 1);
        access(8'h50, 32'h1234_5678, 1, 0, 1);
        access(8'hFF, 32'h1234_5678, 1, 0, 1);
        access(8'h01, 32'hCAFE_F00D, 1, 1, 2);

        // Reset in the middle of a held write.
        exp_q.push_back(model(8'h06, 32'hA5A5_0006, 1, 0));
        bus_addr  = 8'h06;
        bus_wdata = 32'hA5A5_0006;
        bus_wr    = 1'b1;
        @(negedge clk);
        chk("mid_ack", {31'd0, bus_ack}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_ack", {31'd0, bus_ack}, 32'd0);
        chk("async_ctrl", 32'(ctrl_out), 32'd0);
        chk("async_rdata", bus_rdata, 32'd0);
        chk_regs("async_regs");
        @(negedge clk);
        rst_n     = 1'b1;
        bus_wdata = 32'h5A5A_0006;
        repeat (4) @(negedge clk);
        chk("sync_noack", {31'd0, bus_ack}, 32'd0);
        chk_regs("sync_nowrite");
        bus_wr = 1'b0;
        @(negedge clk);

        access(8'h01, 32'h1111_0001, 1, 0, 1);
        access(8'h02, 32'h2222_0002, 1, 0, 1);
        access(8'h01, 32'h0, 0, 1, 1);
        access(8'h02, 32'h0, 0, 1, 1);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] a;
            logic       w;
            logic       r;
            int         sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) a = 8'h00;
            else if (sel == 1) a = 8'hFF;
            else if (sel == 2) a = 8'($urandom);
            else a = 8'($urandom_range(1, N_REG));
            sel = int'($urandom_range(0, 9));
            w = sel < 5 || sel == 9;
            r = sel >= 5;
            access(a, $urandom, w, r, int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vme_reg_file.md
# vme_reg_file

VME-side register file that decodes single-cycle local-bus accesses from the VME slave interface into a packed set of control bits and 32-bit configuration registers. Its flat register outputs feed the two-stage register gate directly downstream, which retimes them for the trigger logic. The block provides readback, an ID register, self-clearing pulse bits, and a strobe-held acknowledge handshake that matches VME DS/DTACK semantics.

## Interface
Parameters:
- N_CTRL, 15, number of control bits (CTRL register bits [N_CTRL-1:0]).
- N_REG, 58, number of 32-bit configuration registers.
- AW, 8, local-bus word-address width.
- PULSE_MASK, 15'h0000, CTRL bits set to 1 here are self-clearing pulses.
- ID_VALUE, 32'h4B4F5430, read-only ID register content.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bus_addr  in  AW  word address, valid while bus_wr or bus_rd is high.
- bus_wdata  in  32  write data.
- bus_wr  in  1  write strobe, held until bus_ack is seen.
- bus_rd  in  1  read strobe, held until bus_ack is seen.
- bus_rdata  out  32  read data, valid while bus_ack=1.
- bus_ack  out  1  acknowledge, held until both strobes are low.
- bus_err  out  1  error qualifier, valid with bus_ack.
- ctrl_out  out  N_CTRL  control bits to downstream gate.
- reg_out  out  N_REG*32  flat registers; REG[k] at bits [32k+31:32k].

## Operation
Address map:
- 0x00 CTRL (R/W).
- 0x01..N_REG REG[addr-1] (R/W).
- 0xFF ID (RO).
- Any other address: error.

FSM states are SYNC, IDLE and BUSY. Reset enters SYNC.
- SYNC: bus_ack=0. Moves to IDLE on the first edge with bus_wr=0 and bus_rd=0. This prevents a strobe held through reset from being executed twice.
- IDLE: on an edge with bus_wr^bus_rd=1, the access executes on that edge and the FSM moves to BUSY.
  - On a write to a valid R/W address, the register is updated on that edge.
  - For a read, bus_rdata latches the addressed value.
  - bus_err is set for an unmapped address or a write to ID. No state changes in that case, and bus_rdata=0.
- IDLE with bus_wr=1 and bus_rd=1 simultaneously: enter BUSY with bus_err=1. No write occurs and bus_rdata=0.
- BUSY: bus_ack=1, and bus_rdata/bus_err hold. Returns to IDLE on the edge after both strobes are seen low. Address or data changes during BUSY are ignored.

Pulse bits (PULSE_MASK=1):
- Writing 1 sets the bit for exactly one clk cycle, then the bit clears automatically.
- Pulse bits always read back 0.

CTRL bits at or above N_CTRL are ignored on write and read back 0.

## Timing
- Reset values: bus_ack=0, bus_err=0, bus_rdata=0, ctrl_out=0, reg_out=0, state=SYNC.
- Write latency: with the strobe first sampled at edge N, ctrl_out/reg_out change at edge N and bus_ack rises at edge N.
- Read latency: bus_rdata is valid at edge N together with bus_ack.
- bus_ack falls on the first edge where both strobes are sampled low. The minimum access is 2 cycles and the next access can start 1 cycle later.
- A pulse bit written at edge N is high from N to N+1 and low at N+1.
- Asynchronous reset mid-access drops bus_ack immediately and clears all registers. The FSM then waits in SYNC for strobe release.
- All outputs are registered; there are no combinational bus paths.

## Structure
- Package vme_reg_pkg contains:
  - Address constants: ADDR_CTRL, ADDR_REG_BASE, ADDR_ID.
  - The state enum {SYNC, IDLE, BUSY}.
  - Default ID_VALUE.
- Single module with inline decode. The register array is a 2-D reg, flattened onto reg_out.

## Test plan
- Write 0x00 data 0x00007FFF, then read 0x00 → ctrl_out=15'h7FFF, bus_rdata=0x00007FFF, bus_err=0, and bus_ack held until the strobe drops.
- Write 0x3A data 0xDEADBEEF → reg_out[1855:1824]=0xDEADBEEF and all other registers remain 0. Read 0xFF → 0x4B4F5430.
- With PULSE_MASK=15'h0001, write CTRL 0x3 → bit0 is high for exactly 1 cycle, bit1 stays high, and readback is 0x2.
- Write to 0x50 or to 0xFF, or assert bus_wr and bus_rd together → bus_ack=1, bus_err=1, and no register changes.
- Assert rst_n low mid-BUSY with bus_wr held → all outputs go to 0 immediately. After release, no second write occurs until the strobe drops and is re-asserted.
- Back-to-back writes to 0x01 and 0x02 with 1 idle cycle between them → both registers are correct, and each bus_ack spans exactly the strobe duration.
